// File: rtl/reset_sequencer_pkg.sv
// Shared types and width helpers for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    LOCK_WAIT,
    DELAY,
    READY,
    RUN,
    HOLD
  } state_t;

  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Control/status bundle between the reset sequencer and the subsystems it releases.
interface reset_sequencer_if #(
  parameter int NUM_STAGES = 3
);
  localparam int SW = reset_seq_pkg::clog2_min1(NUM_STAGES);

  logic                  sw_reset_req;
  logic [NUM_STAGES-1:0] stage_ready;
  logic [NUM_STAGES-1:0] stage_sreset;
  logic                  all_done;
  logic [SW-1:0]         cur_stage;
  logic                  seq_error;

  modport master (
    input  sw_reset_req,
    input  stage_ready,
    output stage_sreset,
    output all_done,
    output cur_stage,
    output seq_error
  );

  modport slave (
    output sw_reset_req,
    output stage_ready,
    input  stage_sreset,
    input  all_done,
    input  cur_stage,
    input  seq_error
  );

endinterface

// File: rtl/reset_sequencer_bit_sync.sv
// Two-flop synchroniser for a single asynchronous level signal.
module bit_sync (
  input  logic clk,
  input  logic areset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Releases per-subsystem synchronous resets in index order after a filtered PLL lock,
// and reasserts them all together on lock loss or software request.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES    = 3,
  parameter int LOCK_FILTER   = 16,
  parameter int STAGE_DELAY   = 100,
  parameter int READY_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              pll_lock,
  reset_sequencer_if.master bus
);

  localparam int SW = clog2_min1(NUM_STAGES);
  localparam int CW = clog2_min1(max3(LOCK_FILTER, STAGE_DELAY, READY_TIMEOUT) + 1);

  localparam logic [CW-1:0] FILTER_LAST  = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] DELAY_LAST   = CW'(STAGE_DELAY - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = (READY_TIMEOUT > 0) ? CW'(READY_TIMEOUT - 1) : '0;
  localparam logic [SW-1:0] STAGE_LAST   = SW'(NUM_STAGES - 1);
  localparam logic [CW-1:0] CTR_MAX      = '1;

  state_t                state_q, state_d;
  logic [CW-1:0]         ctr_q, ctr_d;
  logic [SW-1:0]         stage_q, stage_d;
  logic [NUM_STAGES-1:0] sreset_q, sreset_d;
  logic                  all_done_q, all_done_d;
  logic                  seq_error_q, seq_error_d;

  logic                  lock_s;
  logic [NUM_STAGES-1:0] stage_sel;
  logic                  ready_k;
  logic [CW-1:0]         ctr_inc;
  logic                  lock_lost;
  logic                  sw_accept;
  logic                  timeout_hit;

  bit_sync u_lock_sync (
    .clk    (clk),
    .areset (areset),
    .d      (pll_lock),
    .q      (lock_s)
  );

  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_sel
    assign stage_sel[gi] = (stage_q == SW'(gi));
  end

  assign ready_k   = |(bus.stage_ready & stage_sel);
  assign ctr_inc   = (ctr_q == CTR_MAX) ? ctr_q : ctr_q + CW'(1);
  // Lock loss outranks a software request arriving in the same cycle.
  assign lock_lost = (state_q != LOCK_WAIT) && !lock_s;
  assign sw_accept = (state_q != LOCK_WAIT) && lock_s && bus.sw_reset_req;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q     <= LOCK_WAIT;
      ctr_q       <= '0;
      stage_q     <= '0;
      sreset_q    <= '1;
      all_done_q  <= 1'b0;
      seq_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      stage_q     <= stage_d;
      sreset_q    <= sreset_d;
      all_done_q  <= all_done_d;
      seq_error_q <= seq_error_d;
    end
  end

  // One shared counter: filter in LOCK_WAIT, delay in DELAY/HOLD, timeout in READY.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    stage_d = stage_q;
    if (lock_lost) begin
      state_d = LOCK_WAIT;
      ctr_d   = '0;
      stage_d = '0;
    end else if (sw_accept) begin
      state_d = HOLD;
      ctr_d   = '0;
      stage_d = '0;
    end else begin
      case (state_q)
        LOCK_WAIT: begin
          if (!lock_s) begin
            ctr_d = '0;
          end else if (ctr_q == FILTER_LAST) begin
            state_d = DELAY;
            ctr_d   = '0;
            stage_d = '0;
          end else begin
            ctr_d = ctr_inc;
          end
        end
        DELAY: begin
          if (ctr_q == DELAY_LAST) begin
            state_d = READY;
            ctr_d   = '0;
          end else begin
            ctr_d = ctr_inc;
          end
        end
        READY: begin
          if (ready_k) begin
            ctr_d = '0;
            if (stage_q == STAGE_LAST) begin
              state_d = RUN;
            end else begin
              state_d = DELAY;
              stage_d = stage_q + SW'(1);
            end
          end else begin
            ctr_d = ctr_inc;
          end
        end
        RUN: begin
          ctr_d = '0;
        end
        HOLD: begin
          if (ctr_q == DELAY_LAST) begin
            state_d = DELAY;
            ctr_d   = '0;
          end else begin
            ctr_d = ctr_inc;
          end
        end
        default: begin
          state_d = LOCK_WAIT;
          ctr_d   = '0;
          stage_d = '0;
        end
      endcase
    end
  end

  assign timeout_hit = (READY_TIMEOUT != 0) && (state_q == READY) && (state_d == READY)
                       && (ctr_q >= TIMEOUT_LAST);

  always_comb begin
    sreset_d    = sreset_q;
    all_done_d  = (state_d == RUN);
    seq_error_d = seq_error_q;
    if (state_d == LOCK_WAIT || state_d == HOLD) begin
      sreset_d = '1;
    end else if (state_d == RUN) begin
      sreset_d = '0;
    end else if (state_q == DELAY && state_d == READY) begin
      sreset_d = sreset_q & ~stage_sel;
    end
    if (sw_accept) begin
      seq_error_d = 1'b0;
    end else if (timeout_hit) begin
      seq_error_d = 1'b1;
    end
  end

  // A stage may only be out of reset if every lower-index stage is too.
  for (genvar gi = 1; gi < NUM_STAGES; gi++) begin : g_mono
    assert property (@(posedge clk) disable iff (areset) !sreset_q[gi] |-> !sreset_q[gi-1]);
  end

  assign bus.stage_sreset = sreset_q;
  assign bus.all_done     = all_done_q;
  assign bus.cur_stage    = stage_q;
  assign bus.seq_error    = seq_error_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Reset sequencer bench: directed scenarios with hand-computed edge numbers plus a
// randomized run, all checked every cycle against a release-count based reference model.
module tb_reset_sequencer;

  localparam int N  = 3;
  localparam int LF = 4;
  localparam int SD = 5;
  localparam int RT = 8;

  logic clk      = 1'b0;
  logic areset   = 1'b0;
  logic pll_lock = 1'b0;

  reset_sequencer_if #(.NUM_STAGES(N)) bus_if ();

  reset_sequencer #(
    .NUM_STAGES    (N),
    .LOCK_FILTER   (LF),
    .STAGE_DELAY   (SD),
    .READY_TIMEOUT (RT)
  ) dut (
    .clk      (clk),
    .areset   (areset),
    .pll_lock (pll_lock),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;

  // Reference model: sequencing described by how many stages are released so far.
  bit m_ls1, m_ls, m_active, m_hold, m_wready, m_done, m_err;
  int m_filter, m_released, m_tick;

  int t_rel[N];
  int t_done, t_err;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s edge=%0d got=%0d expected=%0d", name, edge_n, actual, expected);
    end
  endtask

  task automatic model_reset();
    m_ls1 = 0; m_ls = 0; m_active = 0; m_hold = 0; m_wready = 0; m_done = 0; m_err = 0;
    m_filter = 0; m_released = 0; m_tick = 0;
  endtask

  task automatic model_edge();
    if (!m_active) begin
      if (!m_ls) m_filter = 0;
      else if (m_filter == LF - 1) begin
        m_active = 1; m_filter = 0; m_released = 0; m_tick = 0;
        m_wready = 0; m_hold = 0; m_done = 0;
      end else m_filter++;
    end else if (!m_ls) begin
      m_active = 0; m_filter = 0; m_released = 0; m_done = 0; m_hold = 0; m_wready = 0;
    end else if (bus_if.sw_reset_req) begin
      m_hold = 1; m_tick = 0; m_released = 0; m_done = 0; m_wready = 0; m_err = 0;
    end else if (m_hold) begin
      if (m_tick == SD - 1) begin m_hold = 0; m_tick = 0; end
      else m_tick++;
    end else if (m_done) begin
      m_tick = 0;
    end else if (m_wready) begin
      if (bus_if.stage_ready[m_released-1]) begin
        m_wready = 0; m_tick = 0;
        if (m_released == N) m_done = 1;
      end else begin
        m_tick++;
        if (RT != 0 && m_tick >= RT) m_err = 1;
      end
    end else begin
      if (m_tick == SD - 1) begin m_released++; m_wready = 1; m_tick = 0; end
      else m_tick++;
    end
    m_ls  = m_ls1;
    m_ls1 = pll_lock;
  endtask

  task automatic compare_all();
    logic [N-1:0] exp_sr;
    int exp_cur;
    for (int i = 0; i < N; i++) exp_sr[i] = !(m_active && !m_hold && i < m_released);
    exp_cur = 0;
    if (m_active && !m_hold) exp_cur = m_done ? N - 1 : (m_wready ? m_released - 1 : m_released);
    check("stage_sreset", int'(bus_if.stage_sreset), int'(exp_sr));
    check("all_done", int'(bus_if.all_done), int'(m_done));
    check("cur_stage", int'(bus_if.cur_stage), exp_cur);
    check("seq_error", int'(bus_if.seq_error), int'(m_err));
  endtask

  task automatic clear_track();
    for (int i = 0; i < N; i++) t_rel[i] = -1;
    t_done = -1;
    t_err  = -1;
  endtask

  task automatic track();
    for (int i = 0; i < N; i++)
      if (t_rel[i] < 0 && bus_if.stage_sreset[i] == 1'b0) t_rel[i] = edge_n;
    if (t_done < 0 && bus_if.all_done) t_done = edge_n;
    if (t_err < 0 && bus_if.seq_error) t_err = edge_n;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    edge_n++;
    @(negedge clk);
    compare_all();
    track();
  endtask

  task automatic run_to(input int n);
    while (edge_n < n) cycle();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must change without a clock edge.
  task automatic pulse_reset();
    #1 areset = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("rst_sreset", int'(bus_if.stage_sreset), 7);
    check("rst_all_done", int'(bus_if.all_done), 0);
    check("rst_cur_stage", int'(bus_if.cur_stage), 0);
    check("rst_seq_error", int'(bus_if.seq_error), 0);
    @(negedge clk);
    areset = 1'b0;
    edge_n = 0;
    clear_track();
  endtask

  initial begin
    int low_left;
    int thr;
    bus_if.sw_reset_req = 1'b0;
    bus_if.stage_ready  = 3'b111;
    pll_lock = 1'b1;
    model_reset();
    @(negedge clk);

    // Power-up sequencing
    pulse_reset();
    run_to(30);
    check("pwr_rel0_edge", t_rel[0], 11);
    check("pwr_rel1_edge", t_rel[1], 17);
    check("pwr_rel2_edge", t_rel[2], 23);
    check("pwr_done_edge", t_done, 24);

    // Lock loss in RUN, then resequence with stage 1 stalled
    edge_n = 0;
    bus_if.stage_ready = 3'b101;
    pll_lock = 1'b0;
    cycle(); cycle();
    check("loss_still_run", int'(bus_if.stage_sreset), 0);
    cycle();
    check("loss_sreset", int'(bus_if.stage_sreset), 7);
    check("loss_all_done", int'(bus_if.all_done), 0);
    clear_track();
    pll_lock = 1'b1;
    run_to(33);
    check("stall_rel0_edge", t_rel[0], 14);
    check("stall_rel1_edge", t_rel[1], 20);
    check("stall_err_edge", t_err, 28);
    check("stall_stage2_held", int'(bus_if.stage_sreset[2]), 1);
    bus_if.stage_ready = 3'b111;
    run_to(45);
    check("resume_rel2_edge", t_rel[2], 39);
    check("resume_done_edge", t_done, 40);
    check("resume_err_sticky", int'(bus_if.seq_error), 1);

    // Software reset from RUN
    edge_n = 0;
    clear_track();
    bus_if.sw_reset_req = 1'b1;
    cycle();
    bus_if.sw_reset_req = 1'b0;
    check("sw_sreset", int'(bus_if.stage_sreset), 7);
    check("sw_err_cleared", int'(bus_if.seq_error), 0);
    check("sw_all_done", int'(bus_if.all_done), 0);
    run_to(26);
    check("sw_rel0_edge", t_rel[0], 11);
    check("sw_done_edge", t_done, 24);

    // Second request during HOLD restarts the hold count
    edge_n = 0;
    clear_track();
    bus_if.sw_reset_req = 1'b1;
    cycle();
    bus_if.sw_reset_req = 1'b0;
    cycle();
    bus_if.sw_reset_req = 1'b1;
    cycle();
    bus_if.sw_reset_req = 1'b0;
    run_to(30);
    check("hold_restart_rel0_edge", t_rel[0], 13);

    // Build up a sticky error, then lock loss and request in the same cycle
    edge_n = 0;
    clear_track();
    bus_if.stage_ready = 3'b001;
    bus_if.sw_reset_req = 1'b1;
    cycle();
    bus_if.sw_reset_req = 1'b0;
    run_to(28);
    check("pre_simul_rel1_edge", t_rel[1], 17);
    check("pre_simul_err_edge", t_err, 25);
    pll_lock = 1'b0;
    cycle(); cycle();
    bus_if.sw_reset_req = 1'b1;
    cycle();
    bus_if.sw_reset_req = 1'b0;
    check("simul_err_kept", int'(bus_if.seq_error), 1);
    check("simul_sreset", int'(bus_if.stage_sreset), 7);

    // Asynchronous reset in the middle of DELAY(1)
    edge_n = 0;
    bus_if.stage_ready = 3'b111;
    pll_lock = 1'b1;
    run_to(14);
    check("pre_areset_cur_stage", int'(bus_if.cur_stage), 1);
    check("pre_areset_sreset", int'(bus_if.stage_sreset), 6);
    pulse_reset();

    // Lock glitch during filtering
    cycle(); cycle(); cycle();
    pll_lock = 1'b0;
    cycle();
    pll_lock = 1'b1;
    run_to(20);
    check("glitch_rel0_edge", t_rel[0], 15);

    // Randomized traffic with alternating ready bias
    low_left = 0;
    for (int c = 0; c < 1600; c++) begin
      thr = ((c / 200) % 2 == 1) ? 1 : 7;
      if (low_left > 0) begin
        pll_lock = 1'b0;
        low_left--;
      end else begin
        pll_lock = 1'b1;
        if ($urandom_range(0, 199) == 0) low_left = $urandom_range(1, 6);
      end
      bus_if.sw_reset_req = ($urandom_range(0, 79) == 0);
      for (int i = 0; i < N; i++) bus_if.stage_ready[i] = ($urandom_range(0, 7) < thr);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
